booth_pp_gen: RTL and testbench

- Radix-4 Booth partial-product generator for the FPM mantissa multiplier. It sits directly upstream of the first reduction stage and feeds it the 13 partial-product rows.
- Two-stage elastic pipeline:
  - S1 registers the operands and the Booth digit encodings.
  - S2 forms the partial-product rows and registers them.
- Valid/ready handshake on both sides, plus a pass-through sideband tag for the sign and exponent path.

---
 rtl/booth_pp_gen_if.sv | 44 ++++
 rtl/booth_pp_gen.sv | 153 +++++++++++++++
 tb/tb_booth_pp_gen.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_gen_if.sv
// Operand/partial-product bus for the radix-4 Booth generator.
// The master side supplies operands and accepts rows; the slave side is the generator.
interface booth_pp_gen_if #(
    parameter int unsigned TAG_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [22:0]      frac_a;
    logic [22:0]      frac_b;
    logic             zero_in;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic             out_ready;
    logic [25:0]      pp0;
    logic [25:0]      pp1;
    logic [25:0]      pp2;
    logic [25:0]      pp3;
    logic [25:0]      pp4;
    logic [25:0]      pp5;
    logic [25:0]      pp6;
    logic [25:0]      pp7;
    logic [25:0]      pp8;
    logic [25:0]      pp9;
    logic [25:0]      pp10;
    logic [24:0]      pp11;
    logic [22:0]      pp12;
    logic [11:0]      booth_neg;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, frac_a, frac_b, zero_in, tag_in, out_ready,
        input  in_ready, out_valid,
        input  pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9, pp10, pp11, pp12,
        input  booth_neg, tag_out
    );

    modport slave (
        input  in_valid, frac_a, frac_b, zero_in, tag_in, out_ready,
        output in_ready, out_valid,
        output pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9, pp10, pp11, pp12,
        output booth_neg, tag_out
    );
endinterface

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: S1 registers operands and digit encodings,
// S2 forms and registers the 13 rows. Elastic valid/ready on both sides.
module booth_pp_gen #(
    parameter int unsigned TAG_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    booth_pp_gen_if.slave  bus
);
    // Handshake
    logic adv2;
    logic accept;
    logic in_ready_c;
    logic s1_valid;
    logic out_valid_q;

    // B extended with B[-1] = 0 at bit 0 so digit i reads bits [2i+2:2i]
    logic [24:0] b_ext;
    logic [11:0] enc_one;
    logic [11:0] enc_two;
    logic [11:0] enc_neg;

    // S1 state
    logic [22:0]      s1_frac_a;
    logic             s1_zero;
    logic [TAG_W-1:0] s1_tag;
    logic [11:0]      s1_one;
    logic [11:0]      s1_two;
    logic [11:0]      s1_neg;

    // S2 row formation and state
    logic [23:0]      a_full;
    logic [24:0]      mag     [12];
    logic [24:0]      xrow    [12];
    logic [25:0]      row_d   [11];
    logic [24:0]      row11_d;
    logic [22:0]      row12_d;
    logic [11:0]      neg_d;

    logic [25:0]      pp_q    [11];
    logic [24:0]      pp11_q;
    logic [22:0]      pp12_q;
    logic [11:0]      neg_q;
    logic [TAG_W-1:0] tag_q;

    assign adv2       = s1_valid & (~out_valid_q | bus.out_ready);
    assign in_ready_c = ~rst & (~s1_valid | adv2);
    assign accept     = bus.in_valid & in_ready_c;

    assign b_ext = {1'b1, bus.frac_b, 1'b0};

    // Digit 12 is always +1 (B[23] = 1, B[25:24] = 0), so only digits 0..11 are encoded
    always_comb begin
        enc_one = '0;
        enc_two = '0;
        enc_neg = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            logic [2:0] t;
            t          = b_ext[2*i +: 3];
            enc_one[i] = t[1] ^ t[0];
            enc_two[i] = (t == 3'b011) || (t == 3'b100);
            enc_neg[i] = t[2] & ~(t[1] & t[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_frac_a <= '0;
            s1_zero   <= 1'b0;
            s1_tag    <= '0;
            s1_one    <= '0;
            s1_two    <= '0;
            s1_neg    <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_frac_a <= bus.frac_a;
            s1_zero   <= bus.zero_in;
            s1_tag    <= bus.tag_in;
            s1_one    <= enc_one;
            s1_two    <= enc_two;
            s1_neg    <= enc_neg;
        end else if (adv2) begin
            s1_valid  <= 1'b0;
        end
    end

    assign a_full = {1'b1, s1_frac_a};

    always_comb begin
        for (int unsigned i = 0; i < 12; i++) begin
            mag[i] = '0;
            if (s1_one[i]) begin
                mag[i] = {1'b0, a_full};
            end else if (s1_two[i]) begin
                mag[i] = {a_full, 1'b0};
            end
            xrow[i] = mag[i] ^ {25{s1_neg[i]}};
        end
    end

    // A zero product keeps only the sign-extension constant in rows 0..10
    always_comb begin
        for (int unsigned i = 0; i < 11; i++) begin
            row_d[i] = s1_zero ? 26'h2000000 : {~s1_neg[i], xrow[i]};
        end
        row11_d = s1_zero ? '0 : xrow[11];
        row12_d = s1_zero ? '0 : s1_frac_a;
        neg_d   = s1_zero ? '0 : s1_neg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            for (int unsigned i = 0; i < 11; i++) begin
                pp_q[i] <= '0;
            end
            pp11_q <= '0;
            pp12_q <= '0;
            neg_q  <= '0;
            tag_q  <= '0;
        end else if (adv2) begin
            out_valid_q <= 1'b1;
            for (int unsigned i = 0; i < 11; i++) begin
                pp_q[i] <= row_d[i];
            end
            pp11_q <= row11_d;
            pp12_q <= row12_d;
            neg_q  <= neg_d;
            tag_q  <= s1_tag;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.pp0       = pp_q[0];
    assign bus.pp1       = pp_q[1];
    assign bus.pp2       = pp_q[2];
    assign bus.pp3       = pp_q[3];
    assign bus.pp4       = pp_q[4];
    assign bus.pp5       = pp_q[5];
    assign bus.pp6       = pp_q[6];
    assign bus.pp7       = pp_q[7];
    assign bus.pp8       = pp_q[8];
    assign bus.pp9       = pp_q[9];
    assign bus.pp10      = pp_q[10];
    assign bus.pp11      = pp11_q;
    assign bus.pp12      = pp12_q;
    assign bus.booth_neg = neg_q;
    assign bus.tag_out   = tag_q;
endmodule

// File: tb/tb_booth_pp_gen.sv
// Bench for booth_pp_gen: directed cases, back-pressure, throughput and mid-stream reset,
// all checked against an arithmetic Booth model and literal expected rows.
module tb_booth_pp_gen;
    localparam int unsigned TAG_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_pp_gen_if #(.TAG_W(TAG_W)) bus ();
    booth_pp_gen #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [12:0][25:0] pp;
        logic [11:0]       neg;
        logic [9:0]        tag;
    } res_t;

    typedef struct packed {
        logic [22:0] fa;
        logic [22:0] fb;
        logic        z;
        logic [9:0]  tag;
        logic        lit;
        res_t        res;
    } stim_t;

    int    checks = 0;
    int    errors = 0;
    int    n_acc  = 0;
    int    n_pop  = 0;
    logic  last_in_ready;
    stim_t stim_q[$];
    res_t  exp_q[$];

    function automatic int bitof(longint v, int k);
        if (k < 0) return 0;
        return int'((v >> k) & 64'd1);
    endfunction

    // Each row is |d_i| * A, one's-complemented when d_i < 0
    function automatic res_t model(logic [22:0] fa, logic [22:0] fb, logic z, logic [9:0] tag);
        res_t        r;
        longint      a, b, m;
        logic [63:0] x;
        int          d;
        logic        neg;
        r     = '0;
        r.tag = tag;
        if (z) begin
            for (int i = 0; i < 11; i++) r.pp[i] = 26'h2000000;
            return r;
        end
        a = longint'({1'b1, fa});
        b = longint'({1'b1, fb});
        for (int i = 0; i < 12; i++) begin
            d   = -2 * bitof(b, 2*i+1) + bitof(b, 2*i) + bitof(b, 2*i-1);
            m   = longint'((d < 0) ? -d : d) * a;
            neg = (d < 0);
            x   = neg ? (~m & 64'h1FFFFFF) : m;
            if (i < 11) r.pp[i] = {~neg, x[24:0]};
            else        r.pp[i] = 26'(x[24:0]);
            r.neg[i] = neg;
        end
        r.pp[12] = 26'(fa);
        return r;
    endfunction

    function automatic res_t lit(logic [25:0] p0, logic [25:0] p1_10, logic [25:0] p11,
                                 logic [25:0] p12, logic [11:0] n, logic [9:0] t);
        res_t r;
        r.pp[0] = p0;
        for (int i = 1; i < 11; i++) r.pp[i] = p1_10;
        r.pp[11] = p11;
        r.pp[12] = p12;
        r.neg    = n;
        r.tag    = t;
        return r;
    endfunction

    function automatic res_t observe();
        res_t o;
        o.pp[0]  = bus.pp0;  o.pp[1]  = bus.pp1;  o.pp[2]  = bus.pp2;
        o.pp[3]  = bus.pp3;  o.pp[4]  = bus.pp4;  o.pp[5]  = bus.pp5;
        o.pp[6]  = bus.pp6;  o.pp[7]  = bus.pp7;  o.pp[8]  = bus.pp8;
        o.pp[9]  = bus.pp9;  o.pp[10] = bus.pp10;
        o.pp[11] = 26'(bus.pp11);
        o.pp[12] = 26'(bus.pp12);
        o.neg    = bus.booth_neg;
        o.tag    = bus.tag_out;
        return o;
    endfunction

    task automatic chk(input string name, input logic [359:0] o, input logic [359:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, o, e);
        end
    endtask

    task automatic push_rand();
        stim_t s;
        s     = '0;
        s.fa  = 23'($urandom);
        s.fb  = 23'($urandom);
        s.z   = ($urandom_range(0, 15) == 0);
        s.tag = 10'($urandom);
        stim_q.push_back(s);
    endtask

    task automatic push_lit(input logic [22:0] fa, input logic [22:0] fb, input logic z,
                            input logic [9:0] tag, input res_t e);
        stim_t s;
        s.fa = fa; s.fb = fb; s.z = z; s.tag = tag; s.lit = 1'b1; s.res = e;
        stim_q.push_back(s);
    endtask

    // One clock: drive at negedge, check/record transfers at negedge+1, end at posedge+1
    task automatic step(input logic ordy);
        res_t  o, e;
        stim_t s;
        @(negedge clk);
        bus.out_ready = ordy;
        if (stim_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.frac_a   = stim_q[0].fa;
            bus.frac_b   = stim_q[0].fb;
            bus.zero_in  = stim_q[0].z;
            bus.tag_in   = stim_q[0].tag;
        end else begin
            bus.in_valid = 1'b0;
            bus.frac_a   = 23'($urandom);
            bus.frac_b   = 23'($urandom);
            bus.zero_in  = 1'($urandom);
            bus.tag_in   = 10'($urandom);
        end
        #1;
        last_in_ready = bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            n_pop++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out: observed out_valid=1 expected no pending result");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = observe();
                chk("rows", 360'(o.pp), 360'(e.pp));
                chk("booth_neg", 360'(o.neg), 360'(e.neg));
                chk("tag_out", 360'(o.tag), 360'(e.tag));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.lit ? s.res : model(s.fa, s.fb, s.z, s.tag));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || stim_q.size() > 0) && k < max_cycles) begin
            step(1'b1);
            k++;
        end
        checks++;
        assert (exp_q.size() == 0 && stim_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size() + stim_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc0, pop0, k;
        res_t snap;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.frac_a = '0; bus.frac_b = '0; bus.zero_in = 1'b0; bus.tag_in = '0;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 360'(bus.in_ready), 360'(0));
        chk("rst_out_valid", 360'(bus.out_valid), 360'(0));
        chk("rst_outputs", 360'(observe()), 360'(0));
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 360'(bus.in_ready), 360'(1));

        // Hidden bits only, with latency check
        push_lit(23'h0, 23'h0, 1'b0, 10'h155,
                 lit(26'h2000000, 26'h2000000, 26'h0FFFFFF, 26'h0, 12'h800, 10'h155));
        step(1'b1);
        chk("lat1_out_valid", 360'(bus.out_valid), 360'(0));
        step(1'b1);
        chk("lat2_out_valid", 360'(bus.out_valid), 360'(1));
        step(1'b1);

        // All-ones multiplier, then zero flag
        push_lit(23'h0, 23'h7FFFFF, 1'b0, 10'h0AB,
                 lit(26'h17FFFFF, 26'h2000000, 26'h0, 26'h0, 12'h001, 10'h0AB));
        push_lit(23'h7FFFFF, 23'h7FFFFF, 1'b1, 10'h2AA,
                 lit(26'h2000000, 26'h2000000, 26'h0, 26'h0, 12'h000, 10'h2AA));
        drain(10);

        // Back-pressure: 4 pairs, out_ready low from the third cycle
        acc0 = n_acc; pop0 = n_pop;
        repeat (4) push_rand();
        step(1'b1);
        step(1'b1);
        chk("bp_accepts", 360'(n_acc - acc0), 360'(2));
        step(1'b0);
        snap = observe();
        chk("bp_in_ready", 360'(last_in_ready), 360'(0));
        repeat (4) begin
            step(1'b0);
            chk("bp_in_ready_hold", 360'(last_in_ready), 360'(0));
            chk("bp_out_valid_hold", 360'(bus.out_valid), 360'(1));
            chk("bp_outputs_hold", 360'(observe()), 360'(snap));
        end
        drain(20);
        chk("bp_results", 360'(n_pop - pop0), 360'(4));

        // Full throughput: 100 random pairs
        pop0 = n_pop;
        repeat (100) push_rand();
        k = 0;
        while ((n_pop - pop0) < 100 && k < 200) begin
            step(1'b1);
            k++;
        end
        chk("tput_cycles", 360'(k), 360'(102));

        // Reset with both stages full
        repeat (3) push_rand();
        step(1'b0);
        step(1'b0);
        chk("mid_full_out_valid", 360'(bus.out_valid), 360'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 360'(bus.in_ready), 360'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 360'(bus.out_valid), 360'(0));
        chk("mid_rst_in_ready_after", 360'(bus.in_ready), 360'(1));
        chk("mid_rst_outputs", 360'(observe()), 360'(0));
        exp_q.delete();
        stim_q.delete();
        repeat (5) step(1'b1);
        repeat (10) push_rand();
        drain(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
